// File: rtl/mac_pkg.sv
// Shared types and Ethernet constants for the MAC transmit side.
package mac_pkg;

   localparam int BYTE_W        = 8;
   localparam int ETH_IFG_BYTES = 12;
   localparam int ETH_MAX_FRAME = 1514;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_XFER  = 2'd2,
      ST_IFG   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mac_tx_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping from NUM_REQ-1 back to 0 by explicit compare.
module rr_arbiter
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [PTR_W-1:0]   o_idx,
   output logic               o_any
);

   logic [PTR_W:0]   w_sum;
   logic [PTR_W-1:0] w_cand;

   // Scan candidates in priority order starting at the pointer; keep the first hit.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      w_sum    = '0;
      w_cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
         if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
         end
         w_cand = w_sum[PTR_W-1:0];
         if (!o_any && i_req[w_cand]) begin
            o_any            = 1'b1;
            o_idx            = w_cand;
            o_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Shares the mac_tx transmit path between NUM_REQ frame sources: round-robin
// grant, whole-frame byte forwarding with one cycle latency, inter-frame gap,
// and a watchdog that truncates frames longer than MAX_FRAME_BYTES.
module mac_tx_arbiter
   import mac_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int IFG_CYCLES      = ETH_IFG_BYTES,
   parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME
) (
   input  logic                      in_txc,
   input  logic                      in_rst_n,
   input  logic [NUM_REQ-1:0]        in_req,
   input  logic [NUM_REQ-1:0]        in_txen,
   input  logic [BYTE_W*NUM_REQ-1:0] in_txd,
   input  logic                      in_mac_ready,
   output logic [NUM_REQ-1:0]        out_grant,
   output logic                      out_mac_txen,
   output logic [BYTE_W-1:0]         out_mac_txd,
   output logic                      out_busy,
   output logic                      out_abort
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
   localparam int IFG_W = $clog2(IFG_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_FRAME_BYTES);
   localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

   arb_state_t         r_state;
   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   r_win;
   logic [NUM_REQ-1:0] r_grant;
   logic [CNT_W-1:0]   r_byte_cnt;
   logic [IFG_W-1:0]   r_ifg_cnt;
   logic               r_mac_txen;
   logic [BYTE_W-1:0]  r_mac_txd;
   logic               r_abort;

   logic [NUM_REQ-1:0] w_pick_onehot;
   logic [PTR_W-1:0]   w_pick_idx;
   logic               w_pick_any;
   logic               w_txen;
   logic               w_req;
   logic [BYTE_W-1:0]  w_txd;
   logic [PTR_W-1:0]   w_ptr_next;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .i_req    (in_req),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   assign w_txen     = in_txen[r_win];
   assign w_req      = in_req[r_win];
   assign w_ptr_next = (r_win == PTR_LAST) ? '0 : r_win + PTR_W'(1);

   // Select the granted requester's byte lane; other lanes never reach the MAC.
   always_comb begin
      w_txd = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (r_win == PTR_W'(k)) begin
            w_txd = in_txd[k*BYTE_W +: BYTE_W];
         end
      end
   end

   // Arbitration FSM with registered grant, datapath, byte/IFG counters and abort pulse.
   always_ff @(posedge in_txc or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_win      <= '0;
         r_grant    <= '0;
         r_byte_cnt <= '0;
         r_ifg_cnt  <= '0;
         r_mac_txen <= 1'b0;
         r_mac_txd  <= '0;
         r_abort    <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               r_mac_txen <= 1'b0;
               if (in_mac_ready && w_pick_any) begin
                  r_win   <= w_pick_idx;
                  r_grant <= w_pick_onehot;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_txen) begin
                  r_mac_txen <= 1'b1;
                  r_mac_txd  <= w_txd;
                  r_byte_cnt <= CNT_W'(1);
                  r_state    <= ST_XFER;
               end else if (!w_req) begin
                  // Requester withdrew before sending: pointer stays put.
                  r_grant <= '0;
                  r_state <= ST_IDLE;
               end
            end
            ST_XFER: begin
               if (w_txen && (r_byte_cnt != CNT_MAX)) begin
                  r_mac_txen <= 1'b1;
                  r_mac_txd  <= w_txd;
                  r_byte_cnt <= r_byte_cnt + CNT_W'(1);
               end else begin
                  // Either a txen gap (normal end) or an oversize byte (abort, byte dropped).
                  r_mac_txen <= 1'b0;
                  r_abort    <= w_txen;
                  r_grant    <= '0;
                  r_ifg_cnt  <= '0;
                  r_ptr      <= w_ptr_next;
                  r_state    <= ST_IFG;
               end
            end
            ST_IFG: begin
               r_mac_txen <= 1'b0;
               if (r_ifg_cnt == IFG_LAST) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_ifg_cnt <= r_ifg_cnt + IFG_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_grant    = r_grant;
   assign out_mac_txen = r_mac_txen;
   assign out_mac_txd  = r_mac_txd;
   assign out_busy     = (r_state != ST_IDLE);
   assign out_abort    = r_abort;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: reset, single frame, round-robin order,
// ready gating, withdraw, and watchdog truncation on a second instance.
`timescale 1ns/1ps
module tb_mac_tx_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [N-1:0]  txen;
   logic [8*N-1:0] txd;
   logic          ready;

   logic [N-1:0]  gnt, gnt_wd;
   logic          mtxen, mtxen_wd;
   logic [7:0]    mtxd, mtxd_wd;
   logic          busy, busy_wd;
   logic          abort, abort_wd;

   int total = 0;
   int bad   = 0;
   int exp_order [5] = '{0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   mac_tx_arbiter #(.NUM_REQ(N), .IFG_CYCLES(12), .MAX_FRAME_BYTES(1514)) dut (
      .in_txc       (clk),
      .in_rst_n     (rst_n),
      .in_req       (req),
      .in_txen      (txen),
      .in_txd       (txd),
      .in_mac_ready (ready),
      .out_grant    (gnt),
      .out_mac_txen (mtxen),
      .out_mac_txd  (mtxd),
      .out_busy     (busy),
      .out_abort    (abort)
   );

   mac_tx_arbiter #(.NUM_REQ(N), .IFG_CYCLES(12), .MAX_FRAME_BYTES(16)) dut_wd (
      .in_txc       (clk),
      .in_rst_n     (rst_n),
      .in_req       (req),
      .in_txen      (txen),
      .in_txd       (txd),
      .in_mac_ready (ready),
      .out_grant    (gnt_wd),
      .out_mac_txen (mtxen_wd),
      .out_mac_txd  (mtxd_wd),
      .out_busy     (busy_wd),
      .out_abort    (abort_wd)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      txen  = '0;
      txd   = '0;
      ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input int limit, output int n);
      n = 0;
      while (gnt == '0 && n < limit) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int n_high;
      int idx;

      rst_n = 1'b1; req = '0; txen = '0; txd = '0; ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_grant", 32'(gnt), 0);
      chk("rst_txen",  32'(mtxen), 0);
      chk("rst_txd",   32'(mtxd), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_abort", 32'(abort), 0);
      tick();
      tick();
      rst_n = 1'b1;
      ready = 1'b1;

      // Single 64-byte frame from requester 1, junk on the other lanes
      req  = 4'b0010;
      txen = 4'b1101;
      txd  = 32'hA3A2_00A0;
      tick();
      chk("t2_grant", 32'(gnt), 32'h2);
      chk("t2_busy",  32'(busy), 1);
      chk("t2_txen0", 32'(mtxen), 0);
      n_high = 0;
      for (int i = 0; i < 64; i++) begin
         txen[1]    = 1'b1;
         txd[15:8]  = 8'(i);
         tick();
         chk("t2_txd",  32'(mtxd), 32'(i));
         chk("t2_gnt",  32'(gnt), 32'h2);
         if (mtxen) n_high++;
      end
      txen = '0;
      req  = '0;
      tick();
      chk("t2_end_txen", 32'(mtxen), 0);
      chk("t2_end_gnt",  32'(gnt), 0);
      chk("t2_end_hold", 32'(mtxd), 32'h3F);
      n = 1;
      while (busy && n < 40) begin
         tick();
         if (busy) n++;
         if (mtxen) n_high++;
      end
      chk("t2_high_cycles", 32'(n_high), 64);
      chk("t2_ifg_len", 32'(n), 12);

      // Round-robin with all four requesting, 8-byte frames
      do_reset();
      req = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         wait_grant(40, n);
         if (f > 0) chk("t3_gap", 32'(n), 13);
         idx = exp_order[f];
         chk("t3_grant", 32'(gnt), 32'(1) << idx);
         for (int i = 0; i < 8; i++) begin
            txen      = '0;
            txen[idx] = 1'b1;
            txd[8*idx +: 8] = 8'(16*idx + i);
            tick();
            chk("t3_txd", 32'(mtxd), 32'(16*idx + i));
         end
         txen = '0;
         tick();
         chk("t3_end_gnt",  32'(gnt), 0);
         chk("t3_end_txen", 32'(mtxen), 0);
      end
      req = '0;
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      chk("t3_idle", 32'(busy), 0);

      // Withdraw in GRANT: pointer (now 1) must not move
      req = 4'b1000;
      tick();
      chk("t6_grant", 32'(gnt), 32'h8);
      req = '0;
      tick();
      chk("t6_release", 32'(gnt), 0);
      chk("t6_busy",    32'(busy), 0);
      req = 4'b1001;
      tick();
      chk("t6_ptr", 32'(gnt), 32'h8);
      req = '0;
      tick();
      chk("t6_clear", 32'(gnt), 0);

      // Ready gating
      ready = 1'b0;
      req   = 4'b0100;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t4_hold_gnt",  32'(gnt), 0);
         chk("t4_hold_busy", 32'(busy), 0);
      end
      ready = 1'b1;
      tick();
      chk("t4_grant", 32'(gnt), 32'h4);
      ready = 1'b0;
      tick();
      chk("t4_ready_ignored", 32'(gnt), 32'h4);
      req = '0;
      tick();
      chk("t4_release", 32'(gnt), 0);
      ready = 1'b1;

      // Watchdog on the 16-byte instance: 20 bytes offered
      do_reset();
      req = 4'b0001;
      tick();
      chk("t5_grant", 32'(gnt_wd), 32'h1);
      for (int i = 0; i < 20; i++) begin
         txen = 4'b0001;
         txd[7:0] = 8'(8'h80 + i);
         tick();
         if (i < 16) begin
            chk("t5_txen",  32'(mtxen_wd), 1);
            chk("t5_txd",   32'(mtxd_wd), 32'(8'h80 + i));
            chk("t5_abort", 32'(abort_wd), 0);
         end else if (i == 16) begin
            chk("t5_abort_pulse", 32'(abort_wd), 1);
            chk("t5_abort_txen",  32'(mtxen_wd), 0);
            chk("t5_abort_gnt",   32'(gnt_wd), 0);
            chk("t5_abort_busy",  32'(busy_wd), 1);
         end else begin
            chk("t5_post_abort", 32'(abort_wd), 0);
            chk("t5_post_txen",  32'(mtxen_wd), 0);
            chk("t5_post_txd",   32'(mtxd_wd), 32'h8F);
         end
      end
      chk("t5_main_full", 32'(mtxd), 32'h93);
      txen = '0;
      req  = '0;
      tick();
      n = 0;
      while (busy_wd && n < 40) begin
         tick();
         n++;
      end
      chk("t5_idle",     32'(busy_wd), 0);
      chk("t5_idle_gnt", 32'(gnt_wd), 0);

      // Reset mid-frame with every input active
      req   = 4'b1111;
      txen  = 4'b1111;
      txd   = 32'hFFFF_FFFF;
      ready = 1'b1;
      wait_grant(5, n);
      tick();
      tick();
      chk("t1_pre_txen", 32'(mtxen), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t1_gnt",      32'(gnt), 0);
      chk("t1_txen",     32'(mtxen), 0);
      chk("t1_txd",      32'(mtxd), 0);
      chk("t1_busy",     32'(busy), 0);
      chk("t1_abort",    32'(abort), 0);
      chk("t1_wd_gnt",   32'(gnt_wd), 0);
      chk("t1_wd_txen",  32'(mtxen_wd), 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("t1_after_busy", 32'(busy), 0);
      chk("t1_after_gnt",  32'(gnt), 0);
      req  = '0;
      txen = '0;
      tick();
      chk("t1_idle_gnt", 32'(gnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
